// File: rtl/dpram_128x8_fifo_pkg.sv
// Shared sizing constants and types for the dpram_128x8 FIFO controller.
package dpram_fifo_pkg;

   localparam int unsigned DPRAM_DEPTH = 128;
   localparam int unsigned DPRAM_AW    = 7;
   localparam int unsigned DPRAM_DW    = 8;
   localparam int unsigned FIFO_CAP    = 129;
   localparam int unsigned CNT_W       = 8;

   typedef logic [0:DPRAM_AW-1] dpram_addr_t;
   typedef logic [0:DPRAM_DW-1] dpram_data_t;
   typedef logic [0:CNT_W-1]    fifo_cnt_t;

endpackage

// File: rtl/dpram_128x8_fifo_if.sv
// Producer/consumer handshake bundle of the 128x8 FIFO.
// Level/almost flags exist only when DPRAM_FIFO_LEVEL_EN is defined.
interface dpram_128x8_fifo_if;
   import dpram_fifo_pkg::*;

   logic        s_valid;
   logic        s_ready;
   dpram_data_t s_data;
   logic        m_valid;
   logic        m_ready;
   dpram_data_t m_data;
`ifdef DPRAM_FIFO_LEVEL_EN
   fifo_cnt_t   level;
   logic        almost_full;
   logic        almost_empty;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, level, almost_full, almost_empty
   );
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, level, almost_full, almost_empty
   );
`else
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );
`endif

endinterface

// File: rtl/dpram_128x8.sv
// 128x8 simple dual-port RAM: synchronous write, registered read port, no reset.
module dpram_128x8
   import dpram_fifo_pkg::*;
(
   input  logic        clk,
   input  logic        wen,
   input  dpram_addr_t waddr,
   input  dpram_data_t data_in,
   input  logic        ren,
   input  dpram_addr_t raddr,
   output dpram_data_t data_out
);

   dpram_data_t mem_q [DPRAM_DEPTH];
   dpram_data_t data_out_q;

   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= data_in;
      if (ren) data_out_q <= mem_q[raddr];
   end

   assign data_out = data_out_q;

endmodule

// File: rtl/dpram_128x8_fifo.sv
// First-word-fall-through FIFO controller around dpram_128x8; the RAM read register is the output stage.
// Optional DPRAM_FIFO_LEVEL_EN adds level/almost_full/almost_empty outputs.
module dpram_128x8_fifo
   import dpram_fifo_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   dpram_128x8_fifo_if.slave bus
);

`ifdef DPRAM_FIFO_LEVEL_EN
   parameter int unsigned AF_THRESH = 120;
   parameter int unsigned AE_THRESH = 4;
`endif

   localparam fifo_cnt_t RAM_FULL = CNT_W'(DPRAM_DEPTH);

   dpram_addr_t wptr_q, wptr_d;
   dpram_addr_t rptr_q, rptr_d;
   fifo_cnt_t   ram_cnt_q, ram_cnt_d;
   logic        m_valid_q, m_valid_d;
   logic        s_ready_c;
   logic        push_c;
   logic        ren_c;
   dpram_data_t rdata;

   // Handshake decode and next-state; flush overrides both ports.
   always_comb begin
      s_ready_c = (ram_cnt_q != RAM_FULL);
      push_c    = bus.s_valid && s_ready_c && !clr;
      ren_c     = (ram_cnt_q != '0) && (!m_valid_q || bus.m_ready) && !clr;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ram_cnt_d = ram_cnt_q;
      m_valid_d = m_valid_q;
      if (clr) begin
         wptr_d    = '0;
         rptr_d    = '0;
         ram_cnt_d = '0;
         m_valid_d = 1'b0;
      end else begin
         if (push_c) wptr_d = wptr_q + DPRAM_AW'(1);
         if (ren_c)  rptr_d = rptr_q + DPRAM_AW'(1);
         ram_cnt_d = ram_cnt_q + CNT_W'(push_c) - CNT_W'(ren_c);
         if (ren_c)             m_valid_d = 1'b1;
         else if (bus.m_ready)  m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         m_valid_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         m_valid_q <= m_valid_d;
      end
   end

   dpram_128x8 mem (
      .clk      (clk),
      .wen      (push_c),
      .waddr    (wptr_q),
      .data_in  (bus.s_data),
      .ren      (ren_c),
      .raddr    (rptr_q),
      .data_out (rdata)
   );

   assign bus.s_ready = s_ready_c;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = rdata;

`ifdef DPRAM_FIFO_LEVEL_EN
   fifo_cnt_t level_c;

   // Output register holds one word on top of the array count.
   assign level_c          = ram_cnt_q + CNT_W'(m_valid_q);
   assign bus.level        = level_c;
   assign bus.almost_full  = (level_c >= CNT_W'(AF_THRESH));
   assign bus.almost_empty = (level_c <= CNT_W'(AE_THRESH));
`endif

endmodule

// File: tb/tb_dpram_128x8_fifo.sv
// Self-checking bench for dpram_128x8_fifo: queue-level reference model plus directed literal checks.
module tb_dpram_128x8_fifo;

   logic clk;
   logic rst_n;
   logic clr;

   dpram_128x8_fifo_if bus ();

   dpram_128x8_fifo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: words stored behind the head, plus the presented head word.
   logic [7:0] mq [$];
   bit         mv;
   logic [7:0] md;
   bit         acc_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         mq.delete();
         mv = 1'b0;
      end else begin
         acc_m = bus.s_valid && (mq.size() != 128);
         if (mq.size() != 0 && (!mv || bus.m_ready)) begin
            md = mq.pop_front();
            mv = 1'b1;
         end else if (bus.m_ready) begin
            mv = 1'b0;
         end
         if (acc_m) mq.push_back(bus.s_data);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      int lvl;
      lvl = mq.size() + int'(mv);
      check("m_valid", 32'(bus.m_valid), 32'(mv));
      check("s_ready", 32'(bus.s_ready), 32'(mq.size() != 128));
      if (mv) check("m_data", 32'(bus.m_data), 32'(md));
`ifdef DPRAM_FIFO_LEVEL_EN
      check("level", 32'(bus.level), 32'(lvl));
      check("almost_full", 32'(bus.almost_full), 32'(lvl >= 120));
      check("almost_empty", 32'(bus.almost_empty), 32'(lvl <= 4));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      int n;
      logic [7:0] exp_d;
      rst_n       = 1'b0;
      clr         = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      // Reset state
      @(negedge clk);
      compare_model();
      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
`ifdef DPRAM_FIFO_LEVEL_EN
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_ae", 32'(bus.almost_empty), 32'd1);
      check("rst_af", 32'(bus.almost_full), 32'd0);
`endif
      rst_n = 1'b1;

      // Three pushes with consumer stalled: head appears two edges after first push
      bus.s_valid = 1'b1; bus.s_data = 8'h11;
      cycle();
      check("t1_mv_edge1", 32'(bus.m_valid), 32'd0);
      bus.s_data = 8'h22;
      cycle();
      check("t1_mv_edge2", 32'(bus.m_valid), 32'd1);
      check("t1_head", 32'(bus.m_data), 32'h11);
      bus.s_data = 8'h33;
      cycle();
      bus.s_valid = 1'b0;
      cycle();
      check("t1_head_held", 32'(bus.m_data), 32'h11);
`ifdef DPRAM_FIFO_LEVEL_EN
      check("t1_level", 32'(bus.level), 32'd3);
`endif
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("t1_flush_mv", 32'(bus.m_valid), 32'd0);

      // Fill to 129 words, then a refused 130th push
      for (int i = 0; i < 129; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 8'(i);
         cycle();
      end
      check("t2_s_ready_full", 32'(bus.s_ready), 32'd0);
      check("t2_head", 32'(bus.m_data), 32'h00);
`ifdef DPRAM_FIFO_LEVEL_EN
      check("t2_level", 32'(bus.level), 32'd129);
      check("t2_af", 32'(bus.almost_full), 32'd1);
`endif
      bus.s_data = 8'hAA;
      cycle();
      bus.s_valid = 1'b0;
      check("t2_refused_s_ready", 32'(bus.s_ready), 32'd0);

      // Drain 129 words with no gaps
      bus.m_ready = 1'b1;
      for (int i = 0; i < 129; i++) begin
         check("t3_mv", 32'(bus.m_valid), 32'd1);
         check("t3_data", 32'(bus.m_data), 32'(i));
         cycle();
      end
      check("t3_empty_mv", 32'(bus.m_valid), 32'd0);
      check("t3_empty_s_ready", 32'(bus.s_ready), 32'd1);

      // Streaming 300 cycles; pointers wrap
      n = 0;
      for (int c = 0; c < 300; c++) begin
         if (bus.m_valid) begin
            exp_d = 8'(n);
            check("t4_data", 32'(bus.m_data), 32'(exp_d));
            n++;
         end
         bus.s_valid = 1'b1; bus.s_data = 8'(c);
         cycle();
      end
      check("t4_pops", 32'(n), 32'd298);
`ifdef DPRAM_FIFO_LEVEL_EN
      check("t4_level", 32'(bus.level), 32'd2);
`endif
      bus.s_valid = 1'b0;
      for (int c = 0; c < 4; c++) cycle();
      check("t4_drained", 32'(bus.m_valid), 32'd0);

      // 50 queued, flush during push+pop, refill
      bus.m_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 8'(8'h40 + i);
         cycle();
      end
      bus.s_data = 8'hEE; bus.m_ready = 1'b1; clr = 1'b1;
      cycle();
      clr = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
      check("t5_mv", 32'(bus.m_valid), 32'd0);
`ifdef DPRAM_FIFO_LEVEL_EN
      check("t5_level", 32'(bus.level), 32'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 8'(8'hA0 + i);
         cycle();
      end
      bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.m_valid) begin
            exp_d = 8'(8'hA0 + n);
            check("t5_refill", 32'(bus.m_data), 32'(exp_d));
            n++;
         end
         cycle();
      end
      check("t5_count", 32'(n), 32'd5);

      // Asynchronous reset mid-cycle while streaming
      for (int c = 0; c < 10; c++) begin
         bus.s_valid = 1'b1; bus.s_data = 8'(8'hC0 + c);
         cycle();
      end
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_mv", 32'(bus.m_valid), 32'd0);
      check("t6_async_s_ready", 32'(bus.s_ready), 32'd1);
      @(negedge clk);
      compare_model();
      rst_n = 1'b1;
      bus.s_valid = 1'b1; bus.s_data = 8'h5A; bus.m_ready = 1'b0;
      cycle();
      bus.s_valid = 1'b0;
      check("t6_mv_edge1", 32'(bus.m_valid), 32'd0);
      cycle();
      check("t6_mv_edge2", 32'(bus.m_valid), 32'd1);
      check("t6_head", 32'(bus.m_data), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
